// File: rtl/sll_serial.sv
// sll_serial: multi-cycle logical shift-left with carry-out, start/busy/done handshake
module sll_serial #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 16,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] SHAMT,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   OutputSLL,
    output logic               carry
);
    localparam int CW = $clog2(WIDTH + 2);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH:0] w, w_n;
    logic [CW-1:0] cnt, cnt_n, eff, k;
    // Shifting WIDTH+1 places already clears every bit, so larger amounts saturate there
    always_comb eff = (SHAMT > SHAMT_W'(WIDTH + 1)) ? CW'(WIDTH + 1) : CW'(SHAMT);
    always_comb k = (cnt > CW'(STEP)) ? CW'(STEP) : cnt;
    always_comb begin
        state_n = state;
        w_n     = w;
        cnt_n   = cnt;
        case (state)
            IDLE: if (start) begin
                w_n     = {1'b0, A};
                cnt_n   = eff;
                state_n = (eff == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                w_n     = w << k;
                cnt_n   = cnt - k;
                state_n = (cnt == k) ? DONE : SHIFT;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            w         <= '0;
            cnt       <= '0;
            OutputSLL <= '0;
            carry     <= 1'b0;
        end else begin
            state <= state_n;
            w     <= w_n;
            cnt   <= cnt_n;
            if (state_n == DONE && state != DONE) {carry, OutputSLL} <= w_n;
        end
    end
    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_sll_serial.sv
// tb_sll_serial: directed checks of sll_serial with STEP=1 and STEP=4 instances in parallel
module tb_sll_serial;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] SHAMT = '0;
    logic        busy1, done1, carry1, busy4, done4, carry4;
    logic [15:0] out1, out4;
    int          checks = 0;
    int          errors = 0;

    sll_serial #(.WIDTH(16), .SHAMT_W(16), .STEP(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .A(A), .SHAMT(SHAMT),
        .busy(busy1), .done(done1), .OutputSLL(out1), .carry(carry1));
    sll_serial #(.WIDTH(16), .SHAMT_W(16), .STEP(4)) u4 (
        .clk(clk), .reset(reset), .start(start), .A(A), .SHAMT(SHAMT),
        .busy(busy4), .done(done4), .OutputSLL(out4), .carry(carry4));

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation and follows both instances until each pulses done.
    // A start pulse with junk operands is injected in cycle inj (0 = none).
    task automatic run(input logic [15:0] a, input logic [15:0] s, input logic [15:0] eo,
                       input logic ec, input int l1, input int l4, input int inj, input string tag);
        int n = 1;
        int d1 = 0;
        int d4 = 0;
        @(negedge clk);
        start = 1'b1; A = a; SHAMT = s;
        @(negedge clk);
        start = 1'b0; A = ~a; SHAMT = s + 16'd3;
        while ((d1 == 0 || d4 == 0) && n <= 40) begin
            if (done1 && d1 == 0) begin
                d1 = n;
                chk(32'(out1), 32'(eo), {tag, " out1"});
                chk(32'(carry1), 32'(ec), {tag, " carry1"});
                chk(32'(busy1), 1, {tag, " busy1 at done"});
            end
            if (done4 && d4 == 0) begin
                d4 = n;
                chk(32'(out4), 32'(eo), {tag, " out4"});
                chk(32'(carry4), 32'(ec), {tag, " carry4"});
            end
            if (d1 == 0 || d4 == 0) begin
                start = (n == inj);
                if (n == inj) begin A = 16'hFFFF; SHAMT = 16'd1; end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk(32'(d1), 32'(l1), {tag, " latency1"});
        chk(32'(d4), 32'(l4), {tag, " latency4"});
        @(negedge clk);
        chk(32'({busy1, done1}), 0, {tag, " idle after done"});
        chk(32'(out1), 32'(eo), {tag, " out1 held"});
        chk(32'(carry1), 32'(ec), {tag, " carry1 held"});
    endtask

    initial begin
        int pulses = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk(32'({busy1, done1}), 0, "reset busy/done");
        chk(32'(out1), 0, "reset out");
        chk(32'(carry1), 0, "reset carry");
        chk(32'({busy4, done4, carry4}), 0, "reset u4 flags");
        run(16'h8001, 16'd1,     16'h0002, 1'b1, 2,  2, 0, "t1");
        run(16'h1234, 16'd4,     16'h2340, 1'b1, 5,  2, 0, "t2");
        run(16'h1234, 16'd0,     16'h1234, 1'b0, 1,  1, 0, "t3");
        run(16'h0001, 16'd16,    16'h0000, 1'b1, 17, 5, 0, "t4a");
        run(16'hFFFF, 16'h0100,  16'h0000, 1'b0, 18, 6, 0, "t4b");
        run(16'h00F0, 16'd8,     16'hF000, 1'b0, 9,  3, 3, "t5");
        @(negedge clk);
        start = 1'b1; A = 16'hABCD; SHAMT = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk(32'({busy1, done1}), 0, "t6 busy/done after reset");
        chk(32'(out1), 0, "t6 out after reset");
        chk(32'(carry1), 0, "t6 carry after reset");
        chk(32'({busy4, done4, carry4, out4}), 0, "t6 u4 after reset");
        repeat (20) begin
            @(negedge clk);
            if (done1 || done4) pulses++;
        end
        chk(32'(pulses), 0, "t6 no done after reset");
        run(16'hABCD, 16'd10,    16'h3400, 1'b1, 11, 4, 0, "t6 fresh");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
